// File: rtl/tagged_arb_queue.sv
// tagged_arb_queue: circular FIFO that buffers arbiter output together with
// the winning source index, and keeps a running per-source occupancy count
// so upstream credit logic can see how much each requester has queued.
module tagged_arb_queue #(
    parameter int ENTRIES = 4,
    parameter int WIDTH   = 8,
    parameter int N       = 4,
    localparam int TW     = (N > 1) ? $clog2(N) : 1,
    localparam int CW     = $clog2(ENTRIES) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enq_valid,
    output logic              enq_ready,
    input  logic [WIDTH-1:0]  enq_bits,
    input  logic [TW-1:0]     enq_tag,
    output logic              deq_valid,
    input  logic              deq_ready,
    output logic [WIDTH-1:0]  deq_bits,
    output logic [TW-1:0]     deq_tag,
    output logic [CW-1:0]     count,
    output logic [N*CW-1:0]   src_count
);

    localparam int PW = $clog2(ENTRIES);
    localparam int EW = TW + WIDTH;

    // Entry storage: {tag, payload}; intentionally not reset, since an empty
    // queue never presents its contents.
    logic [EW-1:0] mem_q [ENTRIES];

    logic [PW-1:0] enq_ptr_q, enq_ptr_d;
    logic [PW-1:0] deq_ptr_q, deq_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic full;
    logic empty;
    logic do_enq;
    logic do_deq;
    logic [EW-1:0] head;

    // Handshake status depends on the occupancy count only (no pipe or
    // flow-through paths).
    always_comb begin
        full      = (count_q == CW'(ENTRIES));
        empty     = (count_q == '0);
        enq_ready = !full;
        deq_valid = !empty;
        do_enq    = enq_valid && !full;
        do_deq    = deq_ready && !empty;
        head      = mem_q[deq_ptr_q];
        deq_bits  = head[WIDTH-1:0];
        deq_tag   = head[EW-1:WIDTH];
        count     = count_q;
    end

    // Next-state for pointers and total count; pointers wrap naturally
    // because ENTRIES is a power of two.
    always_comb begin
        enq_ptr_d = enq_ptr_q;
        deq_ptr_d = deq_ptr_q;
        count_d   = count_q;
        if (do_enq) begin
            enq_ptr_d = enq_ptr_q + PW'(1);
        end
        if (do_deq) begin
            deq_ptr_d = deq_ptr_q + PW'(1);
        end
        if (do_enq && !do_deq) begin
            count_d = count_q + CW'(1);
        end else if (do_deq && !do_enq) begin
            count_d = count_q - CW'(1);
        end
    end

    // Pointer and count registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            enq_ptr_q <= '0;
            deq_ptr_q <= '0;
            count_q   <= '0;
        end else begin
            enq_ptr_q <= enq_ptr_d;
            deq_ptr_q <= deq_ptr_d;
            count_q   <= count_d;
        end
    end

    // Storage write on an accepted enqueue.
    always_ff @(posedge clk) begin
        if (do_enq) begin
            mem_q[enq_ptr_q] <= {enq_tag, enq_bits};
        end
    end

    // One occupancy counter per source; a same-cycle enq and deq of the
    // same source cancel out.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_src
            logic [CW-1:0] cnt_q, cnt_d;
            logic          inc;
            logic          dec;

            // Per-source increment/decrement decision.
            always_comb begin
                inc   = do_enq && (enq_tag == TW'(gi));
                dec   = do_deq && (deq_tag == TW'(gi));
                cnt_d = cnt_q;
                if (inc && !dec) begin
                    cnt_d = cnt_q + CW'(1);
                end else if (dec && !inc) begin
                    cnt_d = cnt_q - CW'(1);
                end
            end

            // Per-source count register.
            always_ff @(posedge clk) begin
                if (reset) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            assign src_count[gi*CW +: CW] = cnt_q;
        end
    endgenerate

endmodule

// File: tb/tb_tagged_arb_queue.sv
// Self-checking bench for tagged_arb_queue: directed scenarios plus a random
// run, all compared against a queue-based reference model every cycle.
`timescale 1ns/1ps
module tb_tagged_arb_queue;

    localparam int ENTRIES = 4;
    localparam int WIDTH   = 8;
    localparam int N       = 4;
    localparam int TW      = 2;
    localparam int CW      = 3;

    logic              clk;
    logic              reset;
    logic              enq_valid;
    logic              enq_ready;
    logic [WIDTH-1:0]  enq_bits;
    logic [TW-1:0]     enq_tag;
    logic              deq_valid;
    logic              deq_ready;
    logic [WIDTH-1:0]  deq_bits;
    logic [TW-1:0]     deq_tag;
    logic [CW-1:0]     count;
    logic [N*CW-1:0]   src_count;

    tagged_arb_queue #(
        .ENTRIES (ENTRIES),
        .WIDTH   (WIDTH),
        .N       (N)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enq_valid (enq_valid),
        .enq_ready (enq_ready),
        .enq_bits  (enq_bits),
        .enq_tag   (enq_tag),
        .deq_valid (deq_valid),
        .deq_ready (deq_ready),
        .deq_bits  (deq_bits),
        .deq_tag   (deq_tag),
        .count     (count),
        .src_count (src_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a plain queue of {tag, payload} in arrival order.
    logic [TW+WIDTH-1:0] model_q[$];

    int n_checks;
    int n_fail;
    int n_enq;
    int n_deq;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Compare all outputs with the model, apply inputs for one cycle, then
    // advance the model by the handshakes the rules say must fire.
    task automatic step(input bit ev, input logic [WIDTH-1:0] b,
                        input logic [TW-1:0] t, input bit dr);
        int  sz;
        int  exp_src [N];
        bit  fe;
        bit  fd;
        logic [TW+WIDTH-1:0] h;
        enq_valid = ev;
        enq_bits  = b;
        enq_tag   = t;
        deq_ready = dr;
        sz = model_q.size();
        for (int i = 0; i < N; i++) exp_src[i] = 0;
        foreach (model_q[k]) exp_src[int'(model_q[k][TW+WIDTH-1:WIDTH])]++;
        chk("count", 32'(count), 32'(sz));
        chk("enq_ready", 32'(enq_ready), 32'(sz < ENTRIES));
        chk("deq_valid", 32'(deq_valid), 32'(sz > 0));
        if (sz > 0) begin
            h = model_q[0];
            chk("deq_bits", 32'(deq_bits), 32'(h[WIDTH-1:0]));
            chk("deq_tag", 32'(deq_tag), 32'(h[TW+WIDTH-1:WIDTH]));
        end
        for (int i = 0; i < N; i++) begin
            chk($sformatf("src_count[%0d]", i), 32'(src_count[i*CW +: CW]), 32'(exp_src[i]));
        end
        fe = ev && (sz < ENTRIES);
        fd = dr && (sz > 0);
        @(posedge clk);
        if (fd) begin
            void'(model_q.pop_front());
            n_deq++;
        end
        if (fe) begin
            model_q.push_back({t, b});
            n_enq++;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        enq_valid = 1'b0;
        deq_ready = 1'b0;
        reset     = 1'b1;
        @(posedge clk);
        model_q.delete();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        n_enq    = 0;
        n_deq    = 0;
        reset     = 1'b1;
        enq_valid = 1'b0;
        enq_bits  = '0;
        enq_tag   = '0;
        deq_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Idle after reset.
        step(0, 8'h00, 2'd0, 0);
        step(0, 8'h00, 2'd0, 1);

        // Reset with two entries held.
        step(1, 8'hA1, 2'd1, 0);
        step(1, 8'hA2, 2'd3, 0);
        chk("held_before_reset", 32'(count), 32'd2);
        do_reset();
        chk("cnt_after_reset", 32'(count), 32'd0);
        chk("dv_after_reset", 32'(deq_valid), 32'd0);
        step(0, 8'h00, 2'd0, 1);

        // Fill to full, then a rejected fifth enqueue.
        step(1, 8'h11, 2'd0, 0);
        step(1, 8'h22, 2'd1, 0);
        step(1, 8'h33, 2'd2, 0);
        step(1, 8'h44, 2'd3, 0);
        chk("full_count", 32'(count), 32'd4);
        chk("full_enq_ready", 32'(enq_ready), 32'd0);
        step(1, 8'h55, 2'd0, 0);
        chk("reject_fifth", 32'(count), 32'd4);

        // Drain in order.
        for (int i = 0; i < 4; i++) begin
            chk("drain_bits", 32'(deq_bits), 32'(8'h11 * (i + 1)));
            chk("drain_tag", 32'(deq_tag), 32'(i));
            step(0, 8'h00, 2'd0, 1);
        end
        chk("drained_dv", 32'(deq_valid), 32'd0);
        step(0, 8'h00, 2'd0, 1);

        // Hold count at 2 with simultaneous enq/deq across pointer wrap.
        step(1, 8'hE0, 2'd2, 0);
        step(1, 8'hE1, 2'd2, 0);
        for (int i = 0; i < 10; i++) begin
            step(1, 8'(i), 2'd2, 1);
            chk("steady_count", 32'(count), 32'd2);
            chk("steady_src2", 32'(src_count[2*CW +: CW]), 32'd2);
        end
        for (int i = 8; i < 10; i++) begin
            chk("steady_tail", 32'(deq_bits), 32'(i));
            step(0, 8'h00, 2'd0, 1);
        end

        // Full with simultaneous deq: only the deq fires, enq lands next cycle.
        for (int i = 0; i < 4; i++) step(1, 8'(8'h80 + i), 2'(i), 0);
        step(1, 8'h66, 2'd1, 1);
        chk("full_deq_cnt", 32'(count), 32'd3);
        chk("full_deq_ready", 32'(enq_ready), 32'd1);
        step(1, 8'h66, 2'd1, 1);
        chk("full_deq_enq_cnt", 32'(count), 32'd3);
        for (int i = 0; i < 4; i++) step(0, 8'h00, 2'd0, 1);

        // Randomised traffic from a round-robin-like source.
        for (int c = 0; c < 4000; c++) begin
            if (c == 2000) do_reset();
            step($urandom_range(0, 3) != 0, 8'($urandom), 2'($urandom_range(0, N - 1)),
                 $urandom_range(0, 2) != 0);
        end
        for (int i = 0; i < ENTRIES + 1; i++) step(0, 8'h00, 2'd0, 1);
        chk("final_empty", 32'(deq_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Absolute bound so the run always ends.
    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
